// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared states, coin encoding and price defaults for the vending controller
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  function automatic logic [4:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_5:  coin_value = 5'd5;
      COIN_10: coin_value = 5'd10;
      COIN_25: coin_value = 5'd25;
      default: coin_value = 5'd0;
    endcase
  endfunction

  function automatic int default_price(input int i);
    return 10 + 5 * i;
  endfunction

endpackage

// File: rtl/vending_inventory.sv
// rtl/vending_inventory.sv - per-product price and stock table with program and decrement ports
module vending_inventory
  import vending_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int MONEY_W    = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_en,
  input  logic [IDX_W-1:0]   prog_idx,
  input  logic [MONEY_W-1:0] prog_price,
  input  logic [STOCK_W-1:0] prog_stock,
  input  logic               dec_en,
  input  logic [IDX_W-1:0]   dec_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [MONEY_W-1:0] rd_price,
  output logic [STOCK_W-1:0] rd_stock
);

  localparam int NPROD = 2 ** IDX_W;

  logic [MONEY_W-1:0] price_q [NPROD];
  logic [MONEY_W-1:0] price_d [NPROD];
  logic [STOCK_W-1:0] stock_q [NPROD];
  logic [STOCK_W-1:0] stock_d [NPROD];

  // Reads see the stored values, so a same-cycle program lands after the lookup.
  assign rd_price = price_q[rd_idx];
  assign rd_stock = stock_q[rd_idx];

  always_comb begin
    price_d = price_q;
    stock_d = stock_q;
    if (prog_en) begin
      price_d[prog_idx] = prog_price;
      stock_d[prog_idx] = prog_stock;
    end
    if (dec_en && stock_q[dec_idx] != '0) begin
      stock_d[dec_idx] = stock_q[dec_idx] - STOCK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPROD; i++) begin
        price_q[i] <= MONEY_W'(default_price(i));
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      price_q <= price_d;
      stock_q <= stock_d;
    end
  end

endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - purchase FSM, coin accumulator and idle-coin refund timer
module vending_controller
  import vending_pkg::*;
#(
  parameter int CAT_W       = 2,
  parameter int SEL_W       = 2,
  parameter int MONEY_W     = 8,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CAT_W-1:0]       food_categ,
  input  logic [SEL_W-1:0]       select,
  input  logic                   req,
  input  logic [1:0]             coin,
  input  logic                   cancel,
  input  logic                   prog_en,
  input  logic [CAT_W+SEL_W-1:0] prog_idx,
  input  logic [MONEY_W-1:0]     prog_price,
  input  logic [STOCK_W-1:0]     prog_stock,
  output logic [MONEY_W-1:0]     cost_of_product,
  output logic [MONEY_W-1:0]     money_entered,
  output logic [MONEY_W-1:0]     change,
  output logic                   change_valid,
  output logic [CAT_W+SEL_W-1:0] product_out,
  output logic                   product_valid,
  output logic                   sold_out,
  output logic                   coin_reject,
  output logic                   busy
);

  localparam int IDX_W = CAT_W + SEL_W;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, product_out_q, product_out_d;
  logic [MONEY_W-1:0] money_q, money_d, cost_q, cost_d, change_q, change_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic change_valid_q, change_valid_d, product_valid_q, product_valid_d;
  logic sold_out_q, sold_out_d, coin_reject_q, coin_reject_d, busy_q, busy_d;

  logic [MONEY_W-1:0] inv_price;
  logic [STOCK_W-1:0] inv_stock;
  logic [MONEY_W:0]   coin_sum;
  logic               coin_ok;

  vending_inventory #(
    .IDX_W(IDX_W), .MONEY_W(MONEY_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
  ) u_inv (
    .clk       (clk),
    .reset     (reset),
    .prog_en   (prog_en && state_q == ST_IDLE),
    .prog_idx  (prog_idx),
    .prog_price(prog_price),
    .prog_stock(prog_stock),
    .dec_en    (state_q == ST_VEND),
    .dec_idx   (idx_q),
    .rd_idx    ({food_categ, select}),
    .rd_price  (inv_price),
    .rd_stock  (inv_stock)
  );

  // The extra carry bit flags a coin that would wrap the running total.
  assign coin_sum = {1'b0, money_q} + (MONEY_W + 1)'(coin_value(coin));
  assign coin_ok  = (coin != COIN_NONE) && !coin_sum[MONEY_W];

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    money_d         = money_q;
    cost_d          = cost_q;
    timer_d         = timer_q;
    change_d        = '0;
    change_valid_d  = 1'b0;
    product_out_d   = '0;
    product_valid_d = 1'b0;
    sold_out_d      = 1'b0;
    coin_reject_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (inv_stock == '0) begin
            sold_out_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
            idx_d   = {food_categ, select};
            cost_d  = inv_price;
            money_d = '0;
            timer_d = '0;
          end
        end
      end
      ST_COLLECT: begin
        coin_reject_d = (coin != COIN_NONE) && coin_sum[MONEY_W];
        if (coin_ok) begin
          money_d = coin_sum[MONEY_W-1:0];
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (cancel) begin
          state_d        = ST_REFUND;
          change_d       = money_d;
          change_valid_d = 1'b1;
        end else if (money_d >= cost_q) begin
          state_d         = ST_VEND;
          change_d        = money_d - cost_q;
          change_valid_d  = 1'b1;
          product_out_d   = idx_q;
          product_valid_d = 1'b1;
        end else if (!coin_ok && timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d        = ST_REFUND;
          change_d       = money_d;
          change_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        money_d = '0;
        cost_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      money_q         <= '0;
      cost_q          <= '0;
      timer_q         <= '0;
      change_q        <= '0;
      change_valid_q  <= 1'b0;
      product_out_q   <= '0;
      product_valid_q <= 1'b0;
      sold_out_q      <= 1'b0;
      coin_reject_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      money_q         <= money_d;
      cost_q          <= cost_d;
      timer_q         <= timer_d;
      change_q        <= change_d;
      change_valid_q  <= change_valid_d;
      product_out_q   <= product_out_d;
      product_valid_q <= product_valid_d;
      sold_out_q      <= sold_out_d;
      coin_reject_q   <= coin_reject_d;
      busy_q          <= busy_d;
    end
  end

  assign cost_of_product = cost_q;
  assign money_entered   = money_q;
  assign change          = change_q;
  assign change_valid    = change_valid_q;
  assign product_out     = product_out_q;
  assign product_valid   = product_valid_q;
  assign sold_out        = sold_out_q;
  assign coin_reject     = coin_reject_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - directed vector table plus timeout, overflow and reset sequences
module tb_vending_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] food_categ, select, coin;
  logic       req, cancel, prog_en;
  logic [3:0] prog_idx, prog_stock;
  logic [7:0] prog_price;
  logic [7:0] cost_of_product, money_entered, change;
  logic       change_valid, product_valid, sold_out, coin_reject, busy;
  logic [3:0] product_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vending_controller dut (
    .clk(clk), .reset(reset), .food_categ(food_categ), .select(select), .req(req),
    .coin(coin), .cancel(cancel), .prog_en(prog_en), .prog_idx(prog_idx),
    .prog_price(prog_price), .prog_stock(prog_stock), .cost_of_product(cost_of_product),
    .money_entered(money_entered), .change(change), .change_valid(change_valid),
    .product_out(product_out), .product_valid(product_valid), .sold_out(sold_out),
    .coin_reject(coin_reject), .busy(busy)
  );

  typedef struct {
    logic req; logic [1:0] cat; logic [1:0] sel; logic [1:0] coin; logic cancel;
    logic prog_en; logic [3:0] pidx; logic [7:0] pprice; logic [3:0] pstock;
    logic busy; logic [7:0] money; logic [7:0] cost; logic [7:0] chg;
    logic cv; logic pv; logic [3:0] pout; logic so; logic rej;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] s,
                       input logic [1:0] cn, input logic ca);
    req = r; food_categ = c; select = s; coin = cn; cancel = ca;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0);
    prog_en = 0; prog_idx = 0; prog_price = 0; prog_stock = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] outs();
    return {busy, money_entered, cost_of_product, change, change_valid,
            product_valid, product_out, sold_out, coin_reject};
  endfunction

  initial begin
    logic early;
    idle_inputs();

    // req,cat,sel,coin,cancel, prog_en,pidx,pprice,pstock, busy,money,cost,chg,cv,pv,pout,so,rej
    vecs.push_back('{1,3,2,0,0, 0,0,0,0, 1,0,80,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,3,0, 0,0,0,0, 1,25,80,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,3,0, 0,0,0,0, 1,50,80,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,3,0, 0,0,0,0, 1,75,80,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,2,0, 0,0,0,0, 1,85,80,5,1,1,14,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,0,0, 0,0,0,0, 1,0,10,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,1,0, 0,0,0,0, 1,5,10,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,1,1, 0,0,0,0, 1,10,10,10,1,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 1,1,15,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{1,0,1,0,0, 0,0,0,0, 0,0,0,0,0,0,0,1,0});
    vecs.push_back('{0,0,0,3,1, 0,0,0,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{1,0,3,0,0, 1,3,40,3, 1,0,25,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1, 0,0,0,0, 1,0,25,0,1,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{1,0,3,0,0, 0,0,0,0, 1,0,40,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1, 1,3,99,9, 1,0,40,0,1,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{1,0,3,0,0, 0,0,0,0, 1,0,40,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1, 0,0,0,0, 1,0,40,0,1,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 1,5,0,2, 0,0,0,0,0,0,0,0,0});
    vecs.push_back('{1,1,1,0,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 1,0,0,0,1,1,5,0,0});
    vecs.push_back('{0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0});

    repeat (2) tick();
    chk("reset_outputs", 64'(outs()), 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].cat, vecs[i].sel, vecs[i].coin, vecs[i].cancel);
      prog_en = vecs[i].prog_en; prog_idx = vecs[i].pidx;
      prog_price = vecs[i].pprice; prog_stock = vecs[i].pstock;
      tick();
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vecs[i].busy, vecs[i].money, vecs[i].cost, vecs[i].chg, vecs[i].cv,
               vecs[i].pv, vecs[i].pout, vecs[i].so, vecs[i].rej}));
      idle_inputs();
    end
    chk("stock14_after_vend", 64'(dut.u_inv.stock_q[14]), 64'd4);
    chk("stock3_prog_idle_only", 64'(dut.u_inv.stock_q[3]), 64'd3);
    chk("stock5_after_free_vend", 64'(dut.u_inv.stock_q[5]), 64'd1);

    // timeout: 64 coin-free cycles after the last coin
    drive(1, 0, 0, 0, 0); tick(); idle_inputs();
    chk("to_cost", 64'(cost_of_product), 64'd10);
    coin = 2'b01; tick(); idle_inputs();
    chk("to_money", 64'(money_entered), 64'd5);
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (change_valid || !busy) early = 1'b1;
    end
    chk("to_no_early_refund", 64'(early), 64'd0);
    tick();
    chk("to_refund", 64'({change_valid, product_valid, change}), 64'({1'b1, 1'b0, 8'd5}));
    tick();
    chk("to_back_idle", 64'(busy), 64'd0);

    // overflow: price 255, ten quarters, then a refused quarter
    prog_en = 1; prog_idx = 2; prog_price = 255; prog_stock = 5; tick(); idle_inputs();
    drive(1, 0, 2, 0, 0); tick(); idle_inputs();
    chk("ov_cost", 64'(cost_of_product), 64'd255);
    for (int i = 0; i < 10; i++) begin
      coin = 2'b11; tick();
    end
    idle_inputs();
    chk("ov_money250", 64'({busy, money_entered}), 64'({1'b1, 8'd250}));
    coin = 2'b11; tick(); idle_inputs();
    chk("ov_reject", 64'({coin_reject, money_entered, change_valid}), 64'({1'b1, 8'd250, 1'b0}));
    coin = 2'b01; tick(); idle_inputs();
    chk("ov_vend", 64'({money_entered, product_valid, product_out, change_valid, change, coin_reject}),
        64'({8'd255, 1'b1, 4'd2, 1'b1, 8'd0, 1'b0}));
    tick();

    // asynchronous reset in the middle of a purchase
    drive(1, 1, 0, 0, 0); tick(); idle_inputs();
    coin = 2'b10; tick(); tick(); idle_inputs();
    chk("rst_money20", 64'(money_entered), 64'd20);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_outputs", 64'(outs()), 64'd0);
    chk("rst_stock14", 64'(dut.u_inv.stock_q[14]), 64'd5);
    chk("rst_stock1", 64'(dut.u_inv.stock_q[1]), 64'd5);
    chk("rst_price2", 64'(dut.u_inv.price_q[2]), 64'd20);
    chk("rst_price5", 64'(dut.u_inv.price_q[5]), 64'd35);
    @(negedge clk) reset = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (change_valid || busy) early = 1'b1;
    end
    chk("rst_no_change_pulse", 64'(early), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CAT_W, 2, category index width; SEL_W, 2, selection index width; MONEY_W, 8, money/price width; STOCK_W, 4, per-product stock width; INIT_STOCK, 5, stock at reset; TIMEOUT_CYC, 64, idle-coin cycles before auto-refund.
REQ-002 Product count SHALL be NPROD = 2**(CAT_W+SEL_W); product index = {food_categ, select}.
REQ-003 Ports SHALL be (name direction width meaning):
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
food_categ  in  CAT_W  product category
select  in  SEL_W  product within category
req  in  1  purchase request, sampled in IDLE only
coin  in  2  coin per cycle: 00 none, 01 = 5, 10 = 10, 11 = 25
cancel  in  1  abort purchase, refund all money
prog_en  in  1  write price/stock of prog_idx (IDLE only)
prog_idx  in  CAT_W+SEL_W  product index to program
prog_price  in  MONEY_W  new price
prog_stock  in  STOCK_W  new stock count
cost_of_product  out  MONEY_W  price of latched product
money_entered  out  MONEY_W  running coin total
change  out  MONEY_W  amount returned, valid with change_valid
change_valid  out  1  one-cycle pulse
product_out  out  CAT_W+SEL_W  vended product index, valid with product_valid
product_valid  out  1  one-cycle vend pulse
sold_out  out  1  one-cycle pulse: request for zero-stock product
coin_reject  out  1  one-cycle pulse: coin refused (overflow)
busy  out  1  high in any state except IDLE

Function
REQ-004 FSM SHALL have states IDLE, COLLECT, VEND, REFUND; all outputs registered.
REQ-005 IDLE: req with stock[idx]==0 SHALL pulse sold_out next cycle and stay IDLE; with stock>0 SHALL latch idx, load cost_of_product=price[idx], clear money_entered, go COLLECT.
REQ-006 IDLE: coin SHALL be ignored (no accumulation, no reject); cancel ignored.
REQ-007 COLLECT: each nonzero coin SHALL add its value to money_entered at the next edge; if sum exceeds 2**MONEY_W-1 the coin SHALL be refused, coin_reject pulsed, total unchanged.
REQ-008 COLLECT: when the updated total >= cost_of_product (price 0 included), next state SHALL be VEND.
REQ-009 COLLECT: cancel SHALL go REFUND; a coin in the same cycle SHALL be accumulated and included in the refund; cancel outranks the VEND transition.
REQ-010 COLLECT: a counter SHALL reload on every accepted coin and on entry; after TIMEOUT_CYC consecutive coin-free cycles, next state SHALL be REFUND.
REQ-011 VEND (exactly one cycle): product_valid=1, product_out=latched idx, change=money_entered-cost_of_product, change_valid=1, stock[idx] decremented by 1; next state IDLE with money_entered and cost_of_product cleared.
REQ-012 REFUND (exactly one cycle): change=money_entered, change_valid=1, product_valid=0, stock unchanged; next state IDLE, money cleared.
REQ-013 prog_en SHALL write price and stock only in IDLE; ignored in other states. prog_en and req in the same cycle: program first, req evaluated against the old stock/price.
REQ-014 req, food_categ and select SHALL be ignored outside IDLE.

Reset
REQ-015 reset low SHALL immediately force IDLE; all outputs 0; counters cleared; price[i]=default_price(i); stock[i]=INIT_STOCK; any money in flight is discarded.

Structure
REQ-016 Package vending_pkg SHALL hold the state enum, coin encoding constants, coin_value() and default_price(i) = 10 + 5*i.
REQ-017 Price/stock storage with program and decrement ports SHALL be sub-module vending_inventory; FSM, accumulator and timer in vending_controller.

Verification
REQ-018 Exact-plus-change: categ=3, sel=2 (price 80), coins 11,11,11,10 -> money 85, VEND pulse, product_out=14, change=5, stock[14]=4.
REQ-019 Cancel: categ=0, sel=0 (price 10), coin 01, then cancel with coin 01 -> REFUND, change=10, no product_valid.
REQ-020 Sold out: prog idx 1 stock 0, then req idx 1 -> sold_out pulse, state stays IDLE, busy=0.
REQ-021 Timeout: req idx 0, coin 01, 64 coin-free cycles -> REFUND change=5.
REQ-022 Overflow: prog idx 2 price 255, insert 25 x10 (250), then 11 -> coin_reject, money 250; then 01 -> 255, VEND change 0.
REQ-023 Reset mid-COLLECT with money 20 -> outputs 0 asynchronously, stock and prices at defaults, no change pulse.
